viterbi_traceback: RTL and testbench

- Survivor-memory and traceback stage directly downstream of the path-metric unit in the 4-state, K=3, rate-1/2 Viterbi decoder.
- Buffers one survivor decision word per trellis step, then traces back from the winning end state once the block ends.
- Streams the recovered information bits out in forward time order over a valid/ready handshake.

---
 rtl/viterbi_traceback_if.sv | 27 ++
 rtl/viterbi_traceback.sv | 148 ++++++++++++++
 tb/tb_viterbi_traceback.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/viterbi_traceback_if.sv
// Handshake bundle for the Viterbi traceback stage: the decision stream from
// the path-metric unit, the decoded-bit stream to the consumer, and status.
// The slave modport is the traceback block's view; master is the surrounding
// system (path-metric unit plus bit consumer).
interface viterbi_traceback_if;
    logic       dec_valid;
    logic       dec_ready;
    logic [3:0] dec_word;
    logic       dec_last;
    logic [1:0] best_state;
    logic       out_valid;
    logic       out_ready;
    logic       out_bit;
    logic       out_last;
    logic       overflow;
    logic       busy;

    modport master (
        output dec_valid, dec_word, dec_last, best_state, out_ready,
        input  dec_ready, out_valid, out_bit, out_last, overflow, busy
    );

    modport slave (
        input  dec_valid, dec_word, dec_last, best_state, out_ready,
        output dec_ready, out_valid, out_bit, out_last, overflow, busy
    );
endinterface

// File: rtl/viterbi_traceback.sv
// Survivor memory and traceback for the 4-state, K=3, rate-1/2 Viterbi decoder.
// FILL stores one 4-bit decision word per trellis step, TRACE walks the
// survivors backwards from the end state into a bit buffer, and OUTPUT streams
// the bits forward in time over a valid/ready handshake.
// Optional build macro VTB_ZERO_TERM_EN: the encoder is tail-terminated, so the
// traceback always starts from state 0 and best_state is ignored.
module viterbi_traceback #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input logic               clk,
    input logic               rst,
    viterbi_traceback_if.slave vtb
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {S_FILL, S_TRACE, S_OUTPUT} state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]   out_ptr_q, out_ptr_d;
    logic [1:0]         tb_state_q, tb_state_d;
    logic               overflow_q, overflow_d;
    logic               out_valid_q, out_valid_d;
    logic               out_bit_q, out_bit_d;
    logic               out_last_q, out_last_d;

    logic [3:0]         mem [MAX_LEN];
    logic [MAX_LEN-1:0] bitbuf_q;
    logic [3:0]         mem_rd;
    logic [1:0]         start_state;
    logic               accept;
    logic               at_end;

`ifdef VTB_ZERO_TERM_EN
    assign start_state = 2'd0;
`else
    assign start_state = vtb.best_state;
`endif

    assign accept = (state_q == S_FILL) && vtb.dec_valid;
    assign at_end = (wr_ptr_q == LEN_W'(MAX_LEN - 1));
    assign mem_rd = mem[rd_ptr_q[AW-1:0]];

    assign vtb.dec_ready = (state_q == S_FILL);
    assign vtb.busy      = (state_q != S_FILL);
    assign vtb.out_valid = out_valid_q;
    assign vtb.out_bit   = out_bit_q;
    assign vtb.out_last  = out_last_q;
    assign vtb.overflow  = overflow_q;

    // Next-state and datapath update for the FILL / TRACE / OUTPUT sequence.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        len_d       = len_q;
        rd_ptr_d    = rd_ptr_q;
        out_ptr_d   = out_ptr_q;
        tb_state_d  = tb_state_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        out_last_d  = out_last_q;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == '0) overflow_d = 1'b0;
                    if (vtb.dec_last || at_end) begin
                        len_d      = wr_ptr_q + 1'b1;
                        rd_ptr_d   = wr_ptr_q;
                        tb_state_d = start_state;
                        wr_ptr_d   = '0;
                        state_d    = S_TRACE;
                        if (!vtb.dec_last) overflow_d = 1'b1;
                    end
                end
            end
            S_TRACE: begin
                // Step to the predecessor {s[0], survivor bit of s}.
                tb_state_d = {tb_state_q[0], mem_rd[tb_state_q]};
                rd_ptr_d   = rd_ptr_q - 1'b1;
                if (rd_ptr_q == '0) begin
                    rd_ptr_d  = '0;
                    out_ptr_d = '0;
                    state_d   = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                // Load a bit when the register is empty or the current one is taken.
                if (!out_valid_q || vtb.out_ready) begin
                    if (out_valid_q && out_last_q) begin
                        out_valid_d = 1'b0;
                        out_bit_d   = 1'b0;
                        out_last_d  = 1'b0;
                        out_ptr_d   = '0;
                        len_d       = '0;
                        state_d     = S_FILL;
                    end else begin
                        out_valid_d = 1'b1;
                        out_bit_d   = bitbuf_q[out_ptr_q[AW-1:0]];
                        out_last_d  = (out_ptr_q == len_q - 1'b1);
                        out_ptr_d   = out_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // Control and output registers; reset abandons any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q     <= S_FILL;
            wr_ptr_q    <= '0;
            len_q       <= '0;
            rd_ptr_q    <= '0;
            out_ptr_q   <= '0;
            tb_state_q  <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            len_q       <= len_d;
            rd_ptr_q    <= rd_ptr_d;
            out_ptr_q   <= out_ptr_d;
            tb_state_q  <= tb_state_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_last_q  <= out_last_d;
        end
    end

    // Decision memory and bit buffer: written before read within a block.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are not reset; every entry is written before it is read.
        if (accept) mem[wr_ptr_q[AW-1:0]] <= vtb.dec_word;
        if (state_q == S_TRACE) bitbuf_q[rd_ptr_q[AW-1:0]] <= tb_state_q[1];
    end
endmodule

// File: tb/tb_viterbi_traceback.sv
// Self-checking bench for viterbi_traceback. Random blocks come from a forward
// convolutional-encoder model: random information bits drive a state sequence,
// and decision words are built so the survivor path reproduces it, so the
// expected output is simply the information bits.
module tb_viterbi_traceback;
    localparam int MAX_LEN = 32;
`ifdef VTB_ZERO_TERM_EN
    localparam bit ZT = 1'b1;
`else
    localparam bit ZT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    viterbi_traceback_if bus ();

    viterbi_traceback #(.MAX_LEN(MAX_LEN), .LEN_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .vtb (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] words[$];
    bit         exp_bits[$];
    logic [1:0] end_state;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Encoder model: next = {u, cur[1]}; survivor bit of next must be cur[0].
    task automatic gen_block(input int n, input bit term);
        logic [1:0] s;
        logic [1:0] ns;
        logic [3:0] d;
        bit         u;
        words.delete();
        exp_bits.delete();
        s = 2'($urandom_range(0, 3));
        for (int t = 0; t < n; t++) begin
            u = (term && t >= n - 2) ? 1'b0 : 1'($urandom_range(0, 1));
            ns = {u, s[1]};
            d = 4'($urandom);
            d[ns] = s[0];
            words.push_back(d);
            exp_bits.push_back(u);
            s = ns;
        end
        end_state = s;
    endtask

    task automatic send_block(input bit with_last, input logic [1:0] best, output bit ok);
        int w;
        ok = 1'b1;
        for (int i = 0; i < words.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                bus.dec_valid = 1'b0;
                bus.dec_word  = 4'($urandom);
            end
            @(negedge clk);
            bus.dec_valid  = 1'b1;
            bus.dec_word   = words[i];
            bus.dec_last   = with_last && (i == words.size() - 1);
            bus.best_state = (i == words.size() - 1) ? best : 2'($urandom);
            w = 0;
            while (!bus.dec_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (!bus.dec_ready) begin
                check("dec_ready_timeout", 32'(bus.dec_ready), 32'(1));
                ok = 1'b0;
                return;
            end
            @(posedge clk);
        end
    endtask

    // Entered just after the last accepting edge; junk decisions must be ignored.
    task automatic trace_phase(input int len, input bit exp_ovf);
        int k = 0;
        @(negedge clk);
        check("overflow_at_end", 32'(bus.overflow), 32'(exp_ovf));
        bus.dec_valid = 1'b1;
        bus.dec_last  = 1'($urandom);
        while (!bus.out_valid && k < 100) begin
            check("dec_ready_low", 32'(bus.dec_ready), 32'(0));
            check("busy_high", 32'(bus.busy), 32'(1));
            bus.dec_word = 4'($urandom);
            @(negedge clk);
            k++;
        end
        bus.dec_valid = 1'b0;
        bus.dec_last  = 1'b0;
        check("first_valid_latency", 32'(k), 32'(len + 1));
    endtask

    // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready.
    task automatic collect(input int mode);
        int  k = 0;
        int  cyc = 0;
        int  n;
        bit  held = 1'b0;
        bit  rdy;
        logic pb = 1'b0;
        logic pl = 1'b0;
        n = exp_bits.size();
        while (k < n && cyc < 1000) begin
            if (held) begin
                check("hold_valid", 32'(bus.out_valid), 32'(1));
                check("hold_bit", 32'(bus.out_bit), 32'(pb));
                check("hold_last", 32'(bus.out_last), 32'(pl));
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = rdy;
            if (bus.out_valid && rdy) begin
                check("out_bit", 32'(bus.out_bit), 32'(exp_bits[k]));
                check("out_last", 32'(bus.out_last), 32'(k == n - 1));
                k++;
            end
            held = bus.out_valid && !rdy;
            pb   = bus.out_bit;
            pl   = bus.out_last;
            @(negedge clk);
            cyc++;
        end
        if (k < n) check("output_timeout", 32'(k), 32'(n));
        bus.out_ready = 1'b0;
        check("valid_drop", 32'(bus.out_valid), 32'(0));
        check("ready_after_block", 32'(bus.dec_ready), 32'(1));
    endtask

    task automatic run_block(input bit with_last, input logic [1:0] best, input bit exp_ovf,
                             input int mode);
        bit ok;
        send_block(with_last, best, ok);
        if (ok) begin
            trace_phase(words.size(), exp_ovf);
            collect(mode);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst            = 1'b1;
        bus.dec_valid  = 1'b0;
        bus.dec_word   = '0;
        bus.dec_last   = 1'b0;
        bus.best_state = '0;
        bus.out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_out_bit", 32'(bus.out_bit), 32'(0));
        check("rst_out_last", 32'(bus.out_last), 32'(0));
        check("rst_overflow", 32'(bus.overflow), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        check("rst_dec_ready", 32'(bus.dec_ready), 32'(1));

        // Directed 4-step block, best_state 3, then with throttled out_ready.
        for (int m = 0; m < 2; m++) begin
            words = '{4'b0000, 4'b0000, 4'b0100, 4'b0000};
`ifdef VTB_ZERO_TERM_EN
            exp_bits = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
            exp_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
`endif
            run_block(1'b1, 2'd3, 1'b0, m);
        end

        // Single-step block, best_state 2.
        words = '{4'b0000};
`ifdef VTB_ZERO_TERM_EN
        exp_bits = '{1'b0};
`else
        exp_bits = '{1'b1};
`endif
        run_block(1'b1, 2'd2, 1'b0, 0);

        // Full-length block without dec_last: overflow, sticky until next accept.
        gen_block(MAX_LEN, ZT);
        run_block(1'b0, ZT ? 2'($urandom) : end_state, 1'b1, 2);
        check("overflow_sticky", 32'(bus.overflow), 32'(1));
        gen_block(5, ZT);
        run_block(1'b1, ZT ? 2'($urandom) : end_state, 1'b0, 0);
        check("overflow_cleared", 32'(bus.overflow), 32'(0));

        // dec_last on the MAX_LEN-th word is a normal end.
        gen_block(MAX_LEN, ZT);
        run_block(1'b1, ZT ? 2'($urandom) : end_state, 1'b0, 0);
        check("overflow_normal_end", 32'(bus.overflow), 32'(0));

        // Reset pulse in the middle of TRACE.
        begin
            bit ok;
            gen_block(8, ZT);
            send_block(1'b1, end_state, ok);
            bus.dec_valid = 1'b0;
            bus.dec_last  = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            check("midrst_out_valid", 32'(bus.out_valid), 32'(0));
            check("midrst_busy", 32'(bus.busy), 32'(0));
            check("midrst_dec_ready", 32'(bus.dec_ready), 32'(1));
        end
        gen_block(4, ZT);
        run_block(1'b1, ZT ? 2'($urandom) : end_state, 1'b0, 1);

        // Random blocks of assorted lengths and consumer behaviour.
        for (int b = 0; b < 12; b++) begin
            n = ZT ? $urandom_range(2, MAX_LEN) : $urandom_range(1, MAX_LEN);
            gen_block(n, ZT);
            run_block(1'b1, ZT ? 2'($urandom) : end_state, 1'b0, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
